mult_seq_8b: RTL

- Sequential 8x8 unsigned shift-and-add multiplier controller.
- Sequences a single fulladder_8b instance, one add per cycle, to produce a 16-bit product.
- Sits beside the 8-bit adder datapath as its first multi-cycle client.
- Uses a start/busy/done handshake so upstream logic can issue one operation at a time.

---
 rtl/mult_seq_8b.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mult_seq_8b.sv
// Sequential 8x8 unsigned shift-and-add multiplier built around one shared
// 8-bit ripple adder; one add/shift step per clock, start/busy/done handshake.

module fulladder_8b (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic [8:0] carry;

    assign carry[0] = cin;

    genvar i;
    for (i = 0; i < 8; i++) begin : g_bit
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[8];
endmodule

// state | meaning
// IDLE  | waiting for start; product holds last result
// CALC  | eight add/shift steps over {C,A,Q}
// DONE  | one-cycle done pulse; product valid
module mult_seq_8b (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [7:0]  m_reg, a_reg, q_reg;
    logic [3:0]  cnt;

    logic [7:0]  add_sum;
    logic        add_cout;
    logic        c_bit;
    logic [7:0]  a_step, a_shift, q_shift;
    logic        last_step;

    fulladder_8b u_add (
        .a    (a_reg),
        .b    (m_reg),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // The carry never needs storage: it lands in A[7] on the same edge.
    always_comb begin
        c_bit  = 1'b0;
        a_step = a_reg;
        if (q_reg[0]) begin
            c_bit  = add_cout;
            a_step = add_sum;
        end
        a_shift   = {c_bit, a_step[7:1]};
        q_shift   = {a_step[0], q_reg[7:1]};
        last_step = (cnt == 4'd7);
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (last_step) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            m_reg   <= 8'h00;
            a_reg   <= 8'h00;
            q_reg   <= 8'h00;
            cnt     <= 4'd0;
            product <= 16'h0000;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (start) begin
                        m_reg <= a;
                        q_reg <= b;
                        a_reg <= 8'h00;
                        cnt   <= 4'd0;
                    end
                end
                CALC: begin
                    a_reg <= a_shift;
                    q_reg <= q_shift;
                    cnt   <= cnt + 4'd1;
                    // Product captures the post-shift value of the final step.
                    if (last_step) product <= {a_shift, q_shift};
                end
                default: ;
            endcase
        end
    end
endmodule
